// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main control FSM sequencing each instruction over 3-5 cycles
module mc_controller #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [5:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_iord,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_regwrite,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [1:0] o_aluop,
    output logic       o_pcen,
    output logic       o_illegal,
    output logic [3:0] o_state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_pcwrite;
    logic   w_branch;

    // state register; reset returns to FETCH even mid-instruction
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_FETCH;
        else            r_state <= w_next;
    end

    // next-state logic and Moore/handshake output decode
    always_comb begin
        w_next      = S_FETCH;
        w_pcwrite   = 1'b0;
        w_branch    = 1'b0;
        o_iord      = 1'b0;
        o_memwrite  = 1'b0;
        o_irwrite   = 1'b0;
        o_regdst    = 1'b0;
        o_memtoreg  = 1'b0;
        o_regwrite  = 1'b0;
        o_alusrca   = 1'b0;
        o_alusrcb   = 2'b00;
        o_pcsrc     = 2'b00;
        o_aluop     = 2'b00;
        o_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_alusrcb = 2'b01;
                o_irwrite = i_mem_ready;
                w_pcwrite = i_mem_ready;
                w_next    = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                o_alusrcb = 2'b11;
                case (i_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      o_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                w_next    = (i_op == OP_LW) ? S_MEMRD : (i_op == OP_SW) ? S_MEMWR : S_FETCH;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
                w_next = i_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                o_iord     = 1'b1;
                o_memwrite = i_mem_ready;
                w_next     = i_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
            end
            S_EXECUTE: begin
                o_alusrca = 1'b1;
                o_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
            end
            S_ADDIEXEC: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: o_regwrite = 1'b1;
            S_BRANCH: begin
                o_alusrca = 1'b1;
                o_aluop   = 2'b01;
                o_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_JUMP: begin
                o_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign o_pcen  = w_pcwrite | (w_branch & i_zero);
    assign o_state = r_state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized check of mc_controller against an instruction-path queue model
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mc_controller dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_op        (op),
        .i_zero      (zero),
        .i_mem_ready (mem_ready),
        .o_iord      (iord),
        .o_memwrite  (memwrite),
        .o_irwrite   (irwrite),
        .o_regdst    (regdst),
        .o_memtoreg  (memtoreg),
        .o_regwrite  (regwrite),
        .o_alusrca   (alusrca),
        .o_alusrcb   (alusrcb),
        .o_pcsrc     (pcsrc),
        .o_aluop     (aluop),
        .o_pcen      (pcen),
        .o_illegal   (illegal),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // remaining states an opcode walks through after DECODE; empty means unknown opcode
    function automatic void op_path(input logic [5:0] o, output logic [3:0] p [$]);
        p = {};
        case (o)
            6'h23: begin p.push_back(4'd2); p.push_back(4'd3); p.push_back(4'd4); end
            6'h2B: begin p.push_back(4'd2); p.push_back(4'd5); end
            6'h00: begin p.push_back(4'd6); p.push_back(4'd7); end
            6'h04: p.push_back(4'd8);
            6'h08: begin p.push_back(4'd9); p.push_back(4'd10); end
            6'h02: p.push_back(4'd11);
            default: ;
        endcase
    endfunction

    // expected controls {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,pcen,illegal}
    function automatic logic [14:0] exp_ctl(input logic [3:0] s, input logic mr, input logic z, input logic [5:0] o);
        logic io, mw, irw, rd, mtr, rw, asa, pe, il;
        logic [1:0] asb, pcs, aop;
        logic [3:0] p [$];
        {io, mw, irw, rd, mtr, rw, asa, pe, il} = '0;
        {asb, pcs, aop} = '0;
        op_path(o, p);
        case (s)
            4'd0:  begin asb = 2'b01; irw = mr; pe = mr; end
            4'd1:  begin asb = 2'b11; il = (p.size() == 0); end
            4'd2, 4'd9: begin asa = 1'b1; asb = 2'b10; end
            4'd3:  io = 1'b1;
            4'd4:  begin mtr = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = mr; end
            4'd6:  begin asa = 1'b1; aop = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pe = z; end
            4'd10: rw = 1'b1;
            4'd11: begin pcs = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {io, mw, irw, rd, mtr, rw, asa, asb, pcs, aop, pe, il};
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom % 8)
            0: return 6'h23;
            1: return 6'h2B;
            2: return 6'h00;
            3: return 6'h04;
            4: return 6'h08;
            5: return 6'h02;
            6: return 6'h3F;
            default: return 6'($urandom);
        endcase
    endfunction

    logic [3:0] m_state, m_next;
    logic [3:0] q [$];
    logic [14:0] w_act;

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 6'h00;
        @(posedge clk); #1;
        check("rst_state", 32'(state), 32'd0);
        w_act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop, pcen, illegal};
        check("rst_ctl", 32'(w_act), 32'(15'b000_0000_01_00_00_0_0));
        m_state = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            reset_n   = ($urandom % 60) != 0;
            mem_ready = ($urandom % 4) != 0;
            zero      = 1'($urandom);
            if (m_state == 4'd0) op = pick_op();
            #1;
            w_act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop, pcen, illegal};
            check("state", 32'(state), 32'(m_state));
            check("ctl", 32'(w_act), 32'(exp_ctl(m_state, mem_ready, zero, op)));
            if (!reset_n) begin
                m_next = 4'd0;
                q = {};
            end else if ((m_state == 4'd0 || m_state == 4'd3 || m_state == 4'd5) && !mem_ready)
                m_next = m_state;
            else if (m_state == 4'd0)
                m_next = 4'd1;
            else begin
                if (m_state == 4'd1) op_path(op, q);
                m_next = (q.size() != 0) ? q.pop_front() : 4'd0;
            end
            @(posedge clk); #1;
            m_state = m_next;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences one instruction over 3–5 cycles. Each cycle it drives the datapath enables, the mux selects and the 2-bit `aluop`. `aluop`, together with `funct`, feeds the ALU decoder directly downstream, which produces the 3-bit ALU control. The FSM stalls on memory states until `mem_ready` is asserted.

## Interface
Parameters:
- `OP_RTYPE`, 6'h00, R-type opcode
- `OP_LW`, 6'h23, load word
- `OP_SW`, 6'h2B, store word
- `OP_BEQ`, 6'h04, branch if equal
- `OP_ADDI`, 6'h08, add immediate
- `OP_J`, 6'h02, jump

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge
- `op`  in  6  opcode, instr[31:26] from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory access completes this cycle
- `iord`  out  1  memory address select (0 = PC, 1 = ALUOut)
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  instruction register load
- `regdst`  out  1  register file write-address select (1 = rd)
- `memtoreg`  out  1  register file write-data select (1 = data register)
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU A select (1 = register A)
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate
- `pcsrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `aluop`  out  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = use funct
- `pcen`  out  1  PC load: pcwrite | (branch & zero)
- `illegal`  out  1  one-cycle pulse on an unknown opcode
- `state`  out  4  current state encoding, for debug

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Encodings 12–15 are unused and go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE when `mem_ready`=1, else stay in FETCH.
  - DECODE dispatches on `op`: lw/sw → MEMADR, R-type → EXECUTE, beq → BRANCH, addi → ADDIEXEC, j → JUMP, any other value → FETCH with `illegal`=1.
  - MEMADR → MEMRD for lw, MEMWR for sw (re-checks `op`).
  - MEMRD → MEMWB when `mem_ready`=1, else stay.
  - MEMWR → FETCH when `mem_ready`=1, else stay.
  - EXECUTE → ALUWB; ADDIEXEC → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Outputs are decoded from `state`. Any signal not listed for a state is 0.
  - FETCH: `alusrcb`=01, `aluop`=00, `pcsrc`=00, `irwrite`=`mem_ready`, pcwrite=`mem_ready`.
  - DECODE: `alusrcb`=11, `aluop`=00.
  - MEMADR, ADDIEXEC: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMRD: `iord`=1.
  - MEMWR: `iord`=1, `memwrite`=`mem_ready`.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - ALUWB: `regdst`=1, `regwrite`=1.
  - ADDIWB: `regwrite`=1.
  - BRANCH: `alusrca`=1, `aluop`=01, `pcsrc`=01, branch=1.
  - JUMP: `pcsrc`=10, pcwrite=1.
- `illegal` is asserted combinationally only when in DECODE with an unknown opcode.

## Timing
- Reset: when `reset_n`=0 at a rising edge, the next state is FETCH regardless of the current state, including mid-instruction. No write strobe is asserted in the cycle after reset unless FETCH with `mem_ready`=1.
- Reset output values (FETCH): `alusrcb`=01, `irwrite`=`pcen`=`mem_ready`, `illegal`=0, `state`=0, all other outputs 0.
- Latency with `mem_ready` tied high:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake:
  - `memwrite` and `irwrite` assert only in the cycle where `mem_ready`=1.
  - `op` is sampled in DECODE and MEMADR. The IR is stable after FETCH, so `op` must not change before the next FETCH completes.
- `pcen` is combinational. For beq it reflects `zero` in the BRANCH cycle: taken → `pcen`=1 with `pcsrc`=01.
- `aluop`=11 is never driven.

## Test plan
- Reset: drive `reset_n`=0 during EXECUTE → on the next edge `state`=0, `regwrite`=0; `alusrcb`=01 with `mem_ready`=0.
- lw, op=6'h23, `mem_ready`=1 → state sequence 0,1,2,3,4,0; `regwrite`=1 and `memtoreg`=1 only in the state-4 cycle.
- sw, op=6'h2B, `mem_ready` held low for 2 cycles in MEMWR → `state` holds at 5 for 3 cycles; `memwrite` is 1 only in the third cycle; then FETCH.
- beq, op=6'h04: `zero`=1 → `pcen`=1, `pcsrc`=01, `aluop`=01 in state 8; `zero`=0 → `pcen`=0.
- R-type, op=0 → `aluop`=10 in state 6; state 7 gives `regdst`=1, `regwrite`=1. j, op=6'h02 → state 11 gives `pcsrc`=10, `pcen`=1.
- Illegal opcode, op=6'h3F → `illegal`=1 for exactly one cycle in DECODE; next state 0; no write strobes.
